// File: rtl/vga_position_decoder_if.sv
// Pixel-timing receive bus: raster inputs (clk_en/de/vsync) in, decoded coordinates and status out.
interface vga_position_decoder_if #(
  parameter int X_DATA_WIDTH = 10,
  parameter int Y_DATA_WIDTH = 9
);
  logic                    clk_en;
  logic                    de;
  logic                    vsync;
  logic                    pix_valid;
  logic [X_DATA_WIDTH-1:0] x_pos;
  logic [Y_DATA_WIDTH-1:0] y_pos;
  logic                    frame_start;
  logic                    line_err;
  logic                    locked;

  modport master (
    output clk_en, de, vsync,
    input  pix_valid, x_pos, y_pos, frame_start, line_err, locked
  );

  modport slave (
    input  clk_en, de, vsync,
    output pix_valid, x_pos, y_pos, frame_start, line_err, locked
  );
endinterface

// File: rtl/vga_position_decoder.sv
// Rebuilds pixel (x,y) from a de/vsync raster and tracks resolution lock; VGA_POSITION_DECODER_LOCK_CHECK_EN adds per-frame checking.
// Outputs registered one CLK_40 after the enabled sample; no backpressure, the source stalls via clk_en.
module vga_position_decoder #(
  parameter int X_LINE_WIDTH     = 640,
  parameter int Y_LINE_WIDTH     = 480,
  parameter int X_DATA_WIDTH     = $clog2(X_LINE_WIDTH),
  parameter int Y_DATA_WIDTH     = $clog2(Y_LINE_WIDTH),
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK_40,
  input  logic                  reset_n,
  vga_position_decoder_if.slave bus
);
  localparam logic [X_DATA_WIDTH-1:0] X_LAST = X_DATA_WIDTH'(X_LINE_WIDTH - 1);
  localparam logic [Y_DATA_WIDTH-1:0] Y_LAST = Y_DATA_WIDTH'(Y_LINE_WIDTH - 1);
  localparam logic [Y_DATA_WIDTH:0]   Y_FULL = (Y_DATA_WIDTH + 1)'(Y_LINE_WIDTH);

  logic                    de_q;
  logic                    vs_q;
  logic                    x_ovf;
  logic [Y_DATA_WIDTH:0]   line_cnt;
  logic [X_DATA_WIDTH-1:0] x_pos;
  logic [Y_DATA_WIDTH-1:0] y_pos;
  logic                    pix_valid;
  logic                    frame_start;
  logic                    line_err;
  logic                    locked;

  logic                    vs_now;
  logic                    de_fall;
  logic                    vs_edge;
  logic                    line_bad;
  logic [Y_DATA_WIDTH:0]   line_cnt_fall;

  // line_cnt_fall already includes a line ending this cycle, so a frame
  // closed by a coincident de fall and vsync edge is judged complete.
  always_comb begin
    vs_now        = VSYNC_ACTIVE_LOW ? ~bus.vsync : bus.vsync;
    de_fall       = de_q & ~bus.de;
    vs_edge       = vs_now & ~vs_q;
    line_bad      = (x_pos != X_LAST) | x_ovf;
    line_cnt_fall = line_cnt;
    if (de_fall && (line_cnt != Y_FULL)) begin
      line_cnt_fall = line_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      de_q        <= 1'b0;
      vs_q        <= 1'b0;
      x_ovf       <= 1'b0;
      line_cnt    <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
      if (bus.clk_en) begin
        de_q     <= bus.de;
        vs_q     <= vs_now;
        line_cnt <= vs_edge ? '0 : line_cnt_fall;
        if (bus.de) begin
          pix_valid <= 1'b1;
          y_pos     <= (line_cnt >= Y_FULL) ? Y_LAST : line_cnt[Y_DATA_WIDTH-1:0];
          if (!de_q) begin
            x_pos       <= '0;
            x_ovf       <= 1'b0;
            frame_start <= (line_cnt == '0);
          end else if (x_pos == X_LAST) begin
            x_ovf <= 1'b1;
          end else begin
            x_pos <= x_pos + 1'b1;
          end
        end
        if (de_fall) begin
          line_err <= line_bad;
        end
      end
    end
  end

`ifdef VGA_POSITION_DECODER_LOCK_CHECK_EN
  logic frame_bad;
  logic seen_vsync;
  logic frame_good;

  assign frame_good = (line_cnt_fall == Y_FULL) && !(frame_bad || (de_fall && line_bad));

  // Frames that started before the first vsync edge after reset are never judged.
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      frame_bad  <= 1'b0;
      seen_vsync <= 1'b0;
      locked     <= 1'b0;
    end else begin
      if (line_err) begin
        locked <= 1'b0;
      end else if (bus.clk_en && vs_edge && seen_vsync) begin
        locked <= frame_good;
      end
      if (bus.clk_en) begin
        if (vs_edge) begin
          frame_bad  <= 1'b0;
          seen_vsync <= 1'b1;
        end else if ((bus.de && (line_cnt >= Y_FULL)) || (de_fall && line_bad)) begin
          frame_bad <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      locked <= 1'b0;
    end else if (bus.clk_en && vs_edge) begin
      locked <= 1'b1;
    end
  end
`endif

  assign bus.pix_valid   = pix_valid;
  assign bus.x_pos       = x_pos;
  assign bus.y_pos       = y_pos;
  assign bus.frame_start = frame_start;
  assign bus.line_err    = line_err;
  assign bus.locked      = locked;
endmodule

// File: tb/tb_vga_position_decoder.sv
// Bench for vga_position_decoder on a reduced 10x6 raster; frame scenarios table-driven, reset cases hand-written.
module tb_vga_position_decoder;
  localparam int XL = 10;
  localparam int YL = 6;
  localparam int XW = $clog2(XL);
  localparam int YW = $clog2(YL);
  localparam int NV = 13;

  typedef struct {
    int nlines;
    int bad_row;
    int bad_len;
    bit vs_fall;
    bit stall;
    bit lk_def;
    bit lk_undef;
  } vec_t;

  typedef struct {
    bit pv;
    int x;
    int y;
    bit fs;
    bit le;
  } exp_t;

  logic CLK_40;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   stall  = 0;
  exp_t q[$];
  exp_t m;
  vec_t tbl[NV];

  vga_position_decoder_if #(.X_DATA_WIDTH(XW), .Y_DATA_WIDTH(YW)) bus ();

  vga_position_decoder #(
    .X_LINE_WIDTH(XL),
    .Y_LINE_WIDTH(YL),
    .X_DATA_WIDTH(XW),
    .Y_DATA_WIDTH(YW),
    .VSYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK_40 (CLK_40),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial CLK_40 = 1'b0;
  always #5 CLK_40 = ~CLK_40;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, let the DUT sample them, queue what it must show.
  task automatic cyc(input bit ce, input bit d, input bit vs, input bit pv,
                     input int ex, input int ey, input bit fs, input bit le);
    exp_t e;
    bus.clk_en = ce;
    bus.de     = d;
    bus.vsync  = ~vs;
    e = '{pv, ex, ey, fs, le};
    @(posedge CLK_40);
    if (mon_en) q.push_back(e);
    #1;
  endtask

  task automatic en(input bit d, input bit vs, input bit pv, input int ex,
                    input int ey, input bit fs, input bit le);
    if (stall) begin
      cyc(1'b0, d, vs, 1'b0, 0, 0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) cyc(1'b0, d, vs, 1'b0, 0, 0, 1'b0, 1'b0);
    end
    cyc(1'b1, d, vs, pv, ex, ey, fs, le);
  endtask

  task automatic line(input int n, input int row, input bit vs_fall);
    for (int i = 0; i < n; i++)
      en(1'b1, 1'b0, 1'b1, (i < XL) ? i : XL - 1, (row < YL) ? row : YL - 1,
         (i == 0) && (row == 0), 1'b0);
    en(1'b0, vs_fall, 1'b0, 0, 0, 1'b0, n != XL);
    en(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    en(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic vs_pulse();
    en(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    en(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    en(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int nlines, input int bad_row, input int bad_len, input bit vs_fall);
    for (int r = 0; r < nlines; r++)
      line((r == bad_row) ? bad_len : XL, r, vs_fall && (r == nlines - 1));
    if (!vs_fall) vs_pulse();
  endtask

  task automatic chk_lock(input string nm, input bit lk_def, input bit lk_undef);
`ifdef VGA_POSITION_DECODER_LOCK_CHECK_EN
    chk(nm, bus.locked, lk_def);
`else
    chk(nm, bus.locked, lk_undef);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid"}, bus.pix_valid, 0);
    chk({tag, "_x_pos"}, bus.x_pos, 0);
    chk({tag, "_y_pos"}, bus.y_pos, 0);
    chk({tag, "_frame_start"}, bus.frame_start, 0);
    chk({tag, "_line_err"}, bus.line_err, 0);
    chk({tag, "_locked"}, bus.locked, 0);
  endtask

  always @(negedge CLK_40) begin
    if (mon_en && (q.size() > 0)) begin
      m = q.pop_front();
      chk("pix_valid", bus.pix_valid, m.pv);
      if (m.pv) begin
        chk("x_pos", bus.x_pos, m.x);
        chk("y_pos", bus.y_pos, m.y);
      end
      chk("frame_start", bus.frame_start, m.fs);
      chk("line_err", bus.line_err, m.le);
    end
  end

  initial begin
    //          nlines  bad_row bad_len  vs_fall stall lk_def lk_undef
    tbl[0]  = '{YL,     -1,     XL,      1'b0,   1'b0, 1'b1,  1'b1};
    tbl[1]  = '{YL,     -1,     XL,      1'b0,   1'b0, 1'b1,  1'b1};
    tbl[2]  = '{YL,     3,      XL - 1,  1'b0,   1'b0, 1'b0,  1'b1};
    tbl[3]  = '{YL,     -1,     XL,      1'b0,   1'b0, 1'b1,  1'b1};
    tbl[4]  = '{YL,     2,      XL + 4,  1'b0,   1'b0, 1'b0,  1'b1};
    tbl[5]  = '{YL,     -1,     XL,      1'b0,   1'b0, 1'b1,  1'b1};
    tbl[6]  = '{YL + 2, -1,     XL,      1'b0,   1'b0, 1'b0,  1'b1};
    tbl[7]  = '{YL,     -1,     XL,      1'b1,   1'b0, 1'b1,  1'b1};
    tbl[8]  = '{YL,     -1,     XL,      1'b0,   1'b1, 1'b1,  1'b1};
    tbl[9]  = '{YL,     1,      XL - 1,  1'b0,   1'b1, 1'b0,  1'b1};
    tbl[10] = '{YL,     -1,     XL,      1'b1,   1'b1, 1'b1,  1'b1};
    tbl[11] = '{YL - 1, -1,     XL,      1'b0,   1'b0, 1'b0,  1'b1};
    tbl[12] = '{YL,     -1,     XL,      1'b0,   1'b0, 1'b1,  1'b1};

    reset_n    = 1'b1;
    bus.clk_en = 1'b0;
    bus.de     = 1'b0;
    bus.vsync  = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge CLK_40);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;

    vs_pulse();
    chk_lock("locked_first_vsync", 1'b0, 1'b1);

    for (int i = 0; i < NV; i++) begin
      stall = tbl[i].stall;
      frame(tbl[i].nlines, tbl[i].bad_row, tbl[i].bad_len, tbl[i].vs_fall);
      chk_lock($sformatf("locked_row%0d", i), tbl[i].lk_def, tbl[i].lk_undef);
    end
    stall = 1'b0;

    // Reset in the middle of row 2, half way along the line.
    line(XL, 0, 1'b0);
    line(XL, 1, 1'b0);
    for (int i = 0; i < XL / 2; i++) en(1'b1, 1'b0, 1'b1, i, 2, 1'b0, 1'b0);
    mon_en = 1'b0;
    q.delete();
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge CLK_40);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    line(XL / 2, 0, 1'b0);
    for (int r = 1; r < 4; r++) line(XL, r, 1'b0);
    chk_lock("locked_after_release", 1'b0, 1'b0);
    vs_pulse();
    chk_lock("locked_partial_not_evaluated", 1'b0, 1'b1);
    frame(YL, -1, XL, 1'b0);
    chk_lock("locked_reacquired", 1'b1, 1'b1);

    // A clean frame with no vsync edge since reset must not be judged.
    mon_en = 1'b0;
    q.delete();
    reset_n = 1'b0;
    repeat (2) @(posedge CLK_40);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    frame(YL, -1, XL, 1'b0);
    chk_lock("locked_no_prior_vsync", 1'b0, 1'b1);
    frame(YL, -1, XL, 1'b0);
    chk_lock("locked_after_full_frame", 1'b1, 1'b1);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge CLK_40);
    #1;
    chk("scoreboard_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
